// File: rtl/src_sequencer_if.sv
// ---------------------------------------------------------------------------
// src_sequencer_if
// Control bundle between the Mini SRC hardwired sequencer and the datapath.
// Every signal here is a one-cycle strobe that the sequencer decodes from its
// registered state. The only multi-bit field is alu_op.
//
// Modports:
//   master : sequencer side, drives every strobe
//   slave  : datapath side, consumes every strobe
//
// Signals:
//   Gra, Grb, Grc, Rin, Rout, BAout            register select/encode
//   PCout, PCin, IncPC, IRin, MARin,
//   MDRin, MDRout                              PC/IR/memory-interface
//   Read, Write                                RAM enables
//   Yin, Zin, Zhighout, Zlowout, HIin, HIout,
//   LOin, LOout, Cout                          ALU path
//   CONin, InPortout, OutPortin, jal_R15       branch/I/O/link
//   alu_op[4:0]                                ALU operation code
// ---------------------------------------------------------------------------
interface src_sequencer_if;
   logic       Gra, Grb, Grc, Rin, Rout, BAout;
   logic       PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout;
   logic       Read, Write;
   logic       Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout;
   logic       CONin, InPortout, OutPortin, jal_R15;
   logic [4:0] alu_op;

   modport master (
      output Gra, Grb, Grc, Rin, Rout, BAout,
      output PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
      output Read, Write,
      output Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout,
      output CONin, InPortout, OutPortin, jal_R15,
      output alu_op
   );

   modport slave (
      input Gra, Grb, Grc, Rin, Rout, BAout,
      input PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
      input Read, Write,
      input Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout,
      input CONin, InPortout, OutPortin, jal_R15,
      input alu_op
   );
endinterface

// File: rtl/src_sequencer.sv
// ---------------------------------------------------------------------------
// src_sequencer
// Hardwired multi-cycle control FSM for the Mini SRC datapath. It steps fetch
// (T0-T2) and per-opcode execute (T3-T7) and raises every datapath strobe as
// a Moore decode of the registered state plus the opcode of the latched IR.
//
// Parameters:
//   RESET_CYCLES  cycles clear stays high in RESET_ST after reset release (1..7)
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   stop         request halt at the next instruction boundary
//   IR[31:0]     instruction register, opcode = IR[31:27]
//   CON_FF       branch condition flip-flop
//   ctl          src_sequencer_if.master, all datapath strobes and alu_op
//   clear        synchronous datapath clear (high in RESET_ST)
//   run          1 while executing T0..T7, 0 in reset/halt
//   instr_count  (only with INSTR_COUNT_EN) completed-instruction counter
//
// Optional feature macro: INSTR_COUNT_EN
// ---------------------------------------------------------------------------
module src_sequencer #(
   parameter int unsigned RESET_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stop,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   src_sequencer_if.master ctl,
   output logic        clear,
   output logic        run
`ifdef INSTR_COUNT_EN
   ,
   output logic [31:0] instr_count
`endif
);

   typedef enum logic [3:0] {
      RESET_ST, T0, T1, T2, T3, T4, T5, T6, T7, HALT_ST
   } state_t;

   localparam logic [4:0] OP_LD    = 5'b00000;
   localparam logic [4:0] OP_LDI   = 5'b00001;
   localparam logic [4:0] OP_ST    = 5'b00010;
   localparam logic [4:0] OP_ADD   = 5'b00011;
   localparam logic [4:0] OP_RLAST = 5'b01011;
   localparam logic [4:0] OP_IFST  = 5'b01100;
   localparam logic [4:0] OP_ILAST = 5'b01110;
   localparam logic [4:0] OP_MUL   = 5'b01111;
   localparam logic [4:0] OP_DIV   = 5'b10000;
   localparam logic [4:0] OP_NEG   = 5'b10001;
   localparam logic [4:0] OP_NOT   = 5'b10010;
   localparam logic [4:0] OP_BR    = 5'b10011;
   localparam logic [4:0] OP_JR    = 5'b10100;
   localparam logic [4:0] OP_JAL   = 5'b10101;
   localparam logic [4:0] OP_IN    = 5'b10110;
   localparam logic [4:0] OP_OUT   = 5'b10111;
   localparam logic [4:0] OP_MFHI  = 5'b11000;
   localparam logic [4:0] OP_MFLO  = 5'b11001;
   localparam logic [4:0] OP_HALT  = 5'b11011;

   state_t     state_q, state_d;
   logic [2:0] rst_cnt_q, rst_cnt_d;
   logic       stop_req_q, stop_req_d;
   logic [4:0] op;
   logic       last_step;
   logic       ir_unused;

   assign op        = IR[31:27];
   assign ir_unused = ^IR[26:0];

   // Final execute step for each opcode; nop/undefined/halt and the
   // single-step instructions finish in T3.
   function automatic state_t final_step(input logic [4:0] opc);
      state_t s;
      case (opc) inside
         OP_LD, OP_ST:                       s = T7;
         OP_LDI, [OP_ADD:OP_ILAST]:          s = T5;
         OP_MUL, OP_DIV, OP_BR:              s = T6;
         OP_NEG, OP_NOT, OP_JAL:             s = T4;
         default:                            s = T3;
      endcase
      return s;
   endfunction

   assign last_step = (state_q == final_step(op));

   // ---------------- state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= RESET_ST;
         rst_cnt_q  <= '0;
         stop_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         stop_req_q <= stop_req_d;
      end
   end

   // ---------------- next-state logic ----------------
   // A stop pulse is remembered until the instruction boundary so that a
   // request raised mid-instruction still halts without truncating it.
   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      stop_req_d = stop_req_q | stop;
      case (state_q)
         RESET_ST: begin
            if (rst_cnt_q == 3'(RESET_CYCLES - 1)) begin
               state_d   = T0;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 3'd1;
            end
         end
         T0: state_d = T1;
         T1: state_d = T2;
         T2: state_d = T3;
         T3, T4, T5, T6, T7: begin
            if (last_step) begin
               state_d = (op == OP_HALT || stop || stop_req_q) ? HALT_ST : T0;
            end else begin
               case (state_q)
                  T3:      state_d = T4;
                  T4:      state_d = T5;
                  T5:      state_d = T6;
                  T6:      state_d = T7;
                  default: state_d = T0;
               endcase
            end
         end
         default: state_d = state_q;
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      ctl.Gra = 1'b0; ctl.Grb = 1'b0; ctl.Grc = 1'b0;
      ctl.Rin = 1'b0; ctl.Rout = 1'b0; ctl.BAout = 1'b0;
      ctl.PCout = 1'b0; ctl.PCin = 1'b0; ctl.IncPC = 1'b0; ctl.IRin = 1'b0;
      ctl.MARin = 1'b0; ctl.MDRin = 1'b0; ctl.MDRout = 1'b0;
      ctl.Read = 1'b0; ctl.Write = 1'b0;
      ctl.Yin = 1'b0; ctl.Zin = 1'b0; ctl.Zhighout = 1'b0; ctl.Zlowout = 1'b0;
      ctl.HIin = 1'b0; ctl.HIout = 1'b0; ctl.LOin = 1'b0; ctl.LOout = 1'b0;
      ctl.Cout = 1'b0;
      ctl.CONin = 1'b0; ctl.InPortout = 1'b0; ctl.OutPortin = 1'b0;
      ctl.jal_R15 = 1'b0;
      ctl.alu_op = '0;
      clear = (state_q == RESET_ST);
      run   = !(state_q == RESET_ST || state_q == HALT_ST);

      case (state_q)
         T0: begin
            ctl.PCout = 1'b1; ctl.MARin = 1'b1; ctl.IncPC = 1'b1; ctl.PCin = 1'b1;
         end
         T1: begin
            ctl.Read = 1'b1; ctl.MDRin = 1'b1;
         end
         T2: begin
            ctl.MDRout = 1'b1; ctl.IRin = 1'b1;
         end
         T3, T4, T5, T6, T7: begin
            // Memory and branch instructions compute an address, so the ALU adds.
            ctl.alu_op = (op inside {OP_LD, OP_LDI, OP_ST, OP_BR}) ? OP_ADD : op;
            case (op) inside
               OP_LD, OP_LDI, OP_ST: begin
                  case (state_q)
                     T3: begin ctl.Grb = 1'b1; ctl.BAout = 1'b1; ctl.Yin = 1'b1; end
                     T4: begin ctl.Cout = 1'b1; ctl.Zin = 1'b1; end
                     T5: begin
                        ctl.Zlowout = 1'b1;
                        if (op == OP_LDI) begin ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                        else              ctl.MARin = 1'b1;
                     end
                     T6: begin
                        if (op == OP_LD) begin ctl.Read = 1'b1; ctl.MDRin = 1'b1; end
                        else if (op == OP_ST) begin
                           ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.MDRin = 1'b1;
                        end
                     end
                     T7: begin
                        if (op == OP_LD) begin
                           ctl.MDRout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
                        end else if (op == OP_ST) ctl.Write = 1'b1;
                     end
                     default: ;
                  endcase
               end
               [OP_ADD:OP_RLAST], [OP_IFST:OP_ILAST]: begin
                  case (state_q)
                     T3: begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1; end
                     T4: begin
                        ctl.Zin = 1'b1;
                        if (op >= OP_IFST) ctl.Cout = 1'b1;
                        else begin ctl.Grc = 1'b1; ctl.Rout = 1'b1; end
                     end
                     T5: begin ctl.Zlowout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_MUL, OP_DIV: begin
                  case (state_q)
                     T3: begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1; end
                     T4: begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Zin = 1'b1; end
                     T5: begin ctl.Zlowout = 1'b1; ctl.LOin = 1'b1; end
                     T6: begin ctl.Zhighout = 1'b1; ctl.HIin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_NEG, OP_NOT: begin
                  case (state_q)
                     T3: begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Zin = 1'b1; end
                     T4: begin ctl.Zlowout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_BR: begin
                  case (state_q)
                     T3: begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.CONin = 1'b1; end
                     T4: begin ctl.PCout = 1'b1; ctl.Yin = 1'b1; end
                     T5: begin ctl.Cout = 1'b1; ctl.Zin = 1'b1; end
                     T6: if (CON_FF) begin ctl.Zlowout = 1'b1; ctl.PCin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_JR: if (state_q == T3) begin
                  ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1;
               end
               OP_JAL: begin
                  case (state_q)
                     T3: begin ctl.PCout = 1'b1; ctl.jal_R15 = 1'b1; ctl.Rin = 1'b1; end
                     T4: begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_IN: if (state_q == T3) begin
                  ctl.InPortout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
               end
               OP_OUT: if (state_q == T3) begin
                  ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.OutPortin = 1'b1;
               end
               OP_MFHI: if (state_q == T3) begin
                  ctl.HIout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
               end
               OP_MFLO: if (state_q == T3) begin
                  ctl.LOout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

`ifdef INSTR_COUNT_EN
   logic [31:0] instr_count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)          instr_count_q <= '0;
      else if (last_step) instr_count_q <= instr_count_q + 32'd1;
   end

   assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_src_sequencer.sv
module tb_src_sequencer;
   localparam int unsigned RESET_CYCLES = 1;

   // bit positions of the packed output vector used by the model
   localparam int GRA = 0, GRB = 1, GRC = 2, RIN = 3, ROUT = 4, BAOUT = 5;
   localparam int PCOUT = 6, PCIN = 7, INCPC = 8, IRIN = 9, MARIN = 10;
   localparam int MDRIN = 11, MDROUT = 12, READ = 13, WRITE = 14;
   localparam int YIN = 15, ZIN = 16, ZHI = 17, ZLO = 18, HIIN = 19;
   localparam int HIOUT = 20, LOIN = 21, LOOUT = 22, COUT = 23, CONIN = 24;
   localparam int INP = 25, OUTP = 26, JAL = 27, CLR = 28, RUNB = 29;

   logic        clock = 1'b0;
   logic        reset, stop, CON_FF;
   logic [31:0] IR;
   logic        clear, run;
`ifdef INSTR_COUNT_EN
   logic [31:0] instr_count;
`endif

   src_sequencer_if ctl();

   src_sequencer #(.RESET_CYCLES(RESET_CYCLES)) dut (
      .clock(clock), .reset(reset), .stop(stop), .IR(IR), .CON_FF(CON_FF),
      .ctl(ctl), .clear(clear), .run(run)
`ifdef INSTR_COUNT_EN
      , .instr_count(instr_count)
`endif
   );

   always #5 clock = ~clock;

   int compared = 0, mismatched = 0;

   // ---------------- behavioural model ----------------
   typedef enum {M_RESET, M_RUN, M_HALT} mmode_t;
   mmode_t      mode;
   int          rst_left, k, cyc, prev_t0, prev_op;
   logic [34:0] seq[$];
   logic [31:0] cur_ir;
   logic        cur_con, stop_pend, directed;
   logic [31:0] exp_count;
   logic [32:0] dir_q[$];

   function automatic logic [34:0] m(input int a, input int b = -1, input int c = -1);
      logic [34:0] r;
      r = '0;
      r[a] = 1'b1;
      if (b >= 0) r[b] = 1'b1;
      if (c >= 0) r[c] = 1'b1;
      return r;
   endfunction

   // Whole-instruction step list: three fetch steps then the execute steps.
   function automatic void build();
      logic [4:0]  op;
      logic [34:0] alu;
      logic [34:0] ex[$];
      op  = cur_ir[31:27];
      alu = '0;
      alu[34:30] = (op inside {5'd0, 5'd1, 5'd2, 5'd19}) ? 5'd3 : op;
      seq.delete();
      seq.push_back(m(PCOUT, MARIN, INCPC) | m(PCIN));
      seq.push_back(m(READ, MDRIN));
      seq.push_back(m(MDROUT, IRIN));
      case (op) inside
         5'd0:  ex = {m(GRB, BAOUT, YIN), m(COUT, ZIN), m(ZLO, MARIN), m(READ, MDRIN), m(MDROUT, GRA, RIN)};
         5'd1:  ex = {m(GRB, BAOUT, YIN), m(COUT, ZIN), m(ZLO, GRA, RIN)};
         5'd2:  ex = {m(GRB, BAOUT, YIN), m(COUT, ZIN), m(ZLO, MARIN), m(GRA, ROUT, MDRIN), m(WRITE)};
         [5'd3:5'd11]:  ex = {m(GRB, ROUT, YIN), m(GRC, ROUT, ZIN), m(ZLO, GRA, RIN)};
         [5'd12:5'd14]: ex = {m(GRB, ROUT, YIN), m(COUT, ZIN), m(ZLO, GRA, RIN)};
         5'd15, 5'd16:  ex = {m(GRA, ROUT, YIN), m(GRB, ROUT, ZIN), m(ZLO, LOIN), m(ZHI, HIIN)};
         5'd17, 5'd18:  ex = {m(GRB, ROUT, ZIN), m(ZLO, GRA, RIN)};
         5'd19: ex = {m(GRA, ROUT, CONIN), m(PCOUT, YIN), m(COUT, ZIN), cur_con ? m(ZLO, PCIN) : 35'd0};
         5'd20: ex = {m(GRA, ROUT, PCIN)};
         5'd21: ex = {m(PCOUT, JAL, RIN), m(GRA, ROUT, PCIN)};
         5'd22: ex = {m(INP, GRA, RIN)};
         5'd23: ex = {m(GRA, ROUT, OUTP)};
         5'd24: ex = {m(HIOUT, GRA, RIN)};
         5'd25: ex = {m(LOOUT, GRA, RIN)};
         default: ex = {35'd0};
      endcase
      foreach (ex[i]) seq.push_back(ex[i] | alu);
   endfunction

   function automatic void start_instr();
      logic [32:0] d;
      if (dir_q.size() > 0) d = dir_q.pop_front();
      else d = {1'($urandom_range(0, 1)), 32'($urandom)};
      cur_con = d[32];
      cur_ir  = d[31:0];
      build();
      k    = 0;
      mode = M_RUN;
   endfunction

   function automatic void model_reset();
      mode      = M_RESET;
      rst_left  = RESET_CYCLES;
      exp_count = '0;
      stop_pend = 1'b0;
      prev_op   = -1;
   endfunction

   function automatic void model_edge();
      if (reset) begin
         model_reset();
         return;
      end
      case (mode)
         M_RESET: begin
            rst_left--;
            if (rst_left == 0) start_instr();
         end
         M_RUN: begin
            if (k == seq.size() - 1) begin
               exp_count++;
               if (cur_ir[31:27] == 5'b11011 || stop || stop_pend) mode = M_HALT;
               else start_instr();
            end else k++;
         end
         default: ;
      endcase
      stop_pend = stop_pend | stop;
   endfunction

   function automatic logic [34:0] expected();
      case (mode)
         M_RESET: return m(CLR);
         M_RUN:   return seq[k] | m(RUNB);
         default: return '0;
      endcase
   endfunction

   function automatic logic [34:0] dut_vec();
      logic [34:0] r;
      r = '0;
      r[GRA] = ctl.Gra; r[GRB] = ctl.Grb; r[GRC] = ctl.Grc; r[RIN] = ctl.Rin;
      r[ROUT] = ctl.Rout; r[BAOUT] = ctl.BAout; r[PCOUT] = ctl.PCout;
      r[PCIN] = ctl.PCin; r[INCPC] = ctl.IncPC; r[IRIN] = ctl.IRin;
      r[MARIN] = ctl.MARin; r[MDRIN] = ctl.MDRin; r[MDROUT] = ctl.MDRout;
      r[READ] = ctl.Read; r[WRITE] = ctl.Write; r[YIN] = ctl.Yin; r[ZIN] = ctl.Zin;
      r[ZHI] = ctl.Zhighout; r[ZLO] = ctl.Zlowout; r[HIIN] = ctl.HIin;
      r[HIOUT] = ctl.HIout; r[LOIN] = ctl.LOin; r[LOOUT] = ctl.LOout;
      r[COUT] = ctl.Cout; r[CONIN] = ctl.CONin; r[INP] = ctl.InPortout;
      r[OUTP] = ctl.OutPortin; r[JAL] = ctl.jal_R15; r[CLR] = clear; r[RUNB] = run;
      r[34:30] = ctl.alu_op;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // hand-computed expectations for the directed instructions
   task automatic lit_checks();
      logic [4:0] op;
      op = cur_ir[31:27];
      if (ctl.IncPC) begin
         if (prev_op == 3)  check("add_length", 64'(cyc - prev_t0), 64'd6);
         if (prev_op == 2)  check("st_length", 64'(cyc - prev_t0), 64'd8);
         if (prev_op == 19) check("br_length", 64'(cyc - prev_t0), 64'd7);
         prev_op = int'(op);
         prev_t0 = cyc;
      end
      if (k == 0) check("fetch_T0", {ctl.PCout, ctl.MARin, ctl.IncPC, ctl.PCin}, 4'hF);
      if (op == 5'd3 && k == 4) check("add_T4", {ctl.Grc, ctl.Rout, ctl.Zin, ctl.alu_op}, 8'b111_00011);
      if (op == 5'd3 && k == 5) check("add_T5", {ctl.Zlowout, ctl.Gra, ctl.Rin}, 3'b111);
      if (op == 5'd2 && k == 4) check("st_T4_alu", ctl.alu_op, 5'b00011);
      if (op == 5'd2 && k == 6) check("st_T6_write", ctl.Write, 1'b0);
      if (op == 5'd2 && k == 7) check("st_T7_write", ctl.Write, 1'b1);
      if (op == 5'd19 && k == 6) check("br_T6", {ctl.Zlowout, ctl.PCin}, cur_con ? 2'b11 : 2'b00);
      if (op == 5'd15 && k == 6) check("mul_T6_HIin", ctl.HIin, 1'b1);
   endtask

   task automatic tick();
      @(posedge clock);
      cyc++;
      model_edge();
      #1;
   endtask

   task automatic drive_and_check(input logic st);
      stop = st;
      if (mode == M_RUN) begin
         IR = cur_ir;
         CON_FF = cur_con;
      end else begin
         IR = $urandom;
         CON_FF = 1'($urandom_range(0, 1));
      end
      #1;
      check("outputs", dut_vec(), expected());
`ifdef INSTR_COUNT_EN
      check("instr_count", instr_count, exp_count);
`endif
      if (directed && mode == M_RUN) lit_checks();
   endtask

   // asserted just after a clock edge; released mid-cycle n cycles later
   task automatic do_reset(input int n);
      reset = 1'b1;
      model_reset();
      drive_and_check(1'b0);
      check("reset_clear_run", {clear, run}, 2'b10);
      for (int i = 1; i < n; i++) begin
         tick();
         drive_and_check(1'b0);
      end
      tick();
      reset = 1'b0;
      drive_and_check(1'b0);
      check("release_clear", clear, 1'b1);
   endtask

   task automatic run_until_halt();
      for (int i = 0; i < 300 && mode != M_HALT; i++) begin
         tick();
         drive_and_check(mode == M_RUN && cur_ir[31:27] == 5'b01111 && k == 4);
      end
      check("halted_run", {run, clear}, 2'b00);
   endtask

   initial begin
      int rh;
      reset = 1'b1; stop = 1'b0; IR = '0; CON_FF = 1'b0;
      cyc = 0; prev_t0 = 0; directed = 1'b1;
      model_reset();

      // add, st, br not taken, br taken, mul with a stop pulse in T4
      dir_q.push_back({1'b0, 5'b00011, 27'h0123456});
      dir_q.push_back({1'b1, 5'b00010, 27'h0000042});
      dir_q.push_back({1'b0, 5'b10011, 27'h1000000});
      dir_q.push_back({1'b1, 5'b10011, 27'h2000000});
      dir_q.push_back({1'b0, 5'b01111, 27'h0ABCDEF});
      do_reset(3);
      run_until_halt();
      repeat (3) begin
         tick();
         drive_and_check(1'b0);
      end

      // nop, add, halt
      tick();
      dir_q.push_back({1'b0, 5'b11010, 27'h0});
      dir_q.push_back({1'b0, 5'b00011, 27'h0});
      dir_q.push_back({1'b0, 5'b11011, 27'h0});
      do_reset(2);
      run_until_halt();
`ifdef INSTR_COUNT_EN
      check("count_after_halt", instr_count, 32'd3);
      repeat (4) begin
         tick();
         drive_and_check(1'b0);
      end
      check("count_frozen", instr_count, 32'd3);
`endif

      // randomized instruction streams with random stop and reset
      directed = 1'b0;
      tick();
      do_reset(1);
      rh = 0;
      for (int c = 0; c < 5000; c++) begin
         tick();
         if (reset) begin
            if (rh > 0) rh--;
            else reset = 1'b0;
         end else if ((mode == M_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            model_reset();
            rh = $urandom_range(0, 2);
         end
         drive_and_check($urandom_range(0, 59) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/src_sequencer.md
Name: src_sequencer

Overview:
Multi-cycle hardwired control FSM for the Mini SRC datapath. It steps fetch (T0–T2) and per-opcode execute steps (T3–T7), and drives every register-enable, bus-drive, memory and I/O strobe the datapath, IR select/encode, CON FF and RAM interface consume. It sits beside the datapath in the CPU top level, replacing the stub control unit.

Parameters:
RESET_CYCLES, 1, cycles `clear` stays high in RESET_ST after reset deasserts (1..7).

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high
stop  in  1  request halt at next instruction boundary
IR  in  32  instruction register contents; opcode = IR[31:27]
CON_FF  in  1  branch condition flip-flop output
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/encode controls
PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout  out  1 each  PC/IR/memory-interface controls
Read, Write  out  1 each  RAM read/write enables
Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, Cout  out  1 each  ALU-path controls
CONin, InPortout, OutPortin, jal_R15  out  1 each  branch/I/O/link controls
alu_op  out  5  ALU operation code
clear  out  1  synchronous datapath clear
run  out  1  1 = executing, 0 = halted/reset

Behaviour:
- Moore FSM; all outputs decode from registered state only (no IR-to-output path within a step except opcode decode of the latched IR). Unlisted outputs are 0 in every step.
- States: RESET_ST, T0..T7, HALT_ST. reset high → RESET_ST immediately; all outputs 0 except clear=1, run=0. After release: RESET_CYCLES cycles in RESET_ST (clear=1), then T0. Reset mid-instruction aborts with no further strobes.
- Fetch: T0 PCout,MARin,IncPC,PCin; T1 Read,MDRin; T2 MDRout,IRin. run=1 in T0..T7.
- alu_op = IR[31:27] in execute, except ld/ldi/st/br address steps, which force ADD (00011).
- Opcodes/execute (last listed step returns to T0):
  ld 00000: T3 Grb,BAout,Yin; T4 Cout,Zin; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
  ldi 00001: T3–T4 as ld; T5 Zlowout,Gra,Rin.
  st 00010: T3–T5 as ld; T6 Gra,Rout,MDRin; T7 Write.
  R-ALU 00011–01011: T3 Grb,Rout,Yin; T4 Grc,Rout,Zin; T5 Zlowout,Gra,Rin.
  I-ALU 01100–01110: T3 Grb,Rout,Yin; T4 Cout,Zin; T5 Zlowout,Gra,Rin.
  mul 01111 / div 10000: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin.
  neg 10001 / not 10010: T3 Grb,Rout,Zin; T4 Zlowout,Gra,Rin.
  br 10011: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin; T6 Zlowout,PCin only if CON_FF=1, else idle step.
  jr 10100: T3 Gra,Rout,PCin. jal 10101: T3 PCout,jal_R15,Rin; T4 Gra,Rout,PCin.
  in 10110: T3 InPortout,Gra,Rin. out 10111: T3 Gra,Rout,OutPortin.
  mfhi 11000: T3 HIout,Gra,Rin. mflo 11001: T3 LOout,Gra,Rin.
  nop 11010 and undefined 11100–11111: no T3 strobes; T3 → T0.
  halt 11011: T3 → HALT_ST.
- stop sampled at each instruction's last step: if 1 → HALT_ST instead of T0. stop mid-instruction never truncates it.
- HALT_ST: all outputs 0, run=0; exits only via reset.

Optional Feature:
INSTR_COUNT_EN: adds output `instr_count[31:0]`, incremented on each last execute step (halt included), cleared by reset, wraps at 2^32-1 → 0. Without the macro, the port and counter are absent.

Test Plan:
- Reset held 3 cycles, release, RESET_CYCLES=1 → clear=1 for 1 cycle after release, then T0 with PCout=MARin=IncPC=PCin=1.
- IR=add (opcode 00011) → T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with alu_op=00011, T5 Zlowout/Gra/Rin; next fetch in cycle 6 (total 6 cycles).
- IR=st → Write high exactly in T7, alu_op=00011 in T4, 8-cycle instruction.
- IR=br, CON_FF=0 → no PCin in T6; with CON_FF=1 → Zlowout+PCin in T6.
- stop pulsed during T4 of mul → HIin still in T6, then HALT_ST with run=0; reset pulse restarts at RESET_ST.
- INSTR_COUNT_EN: execute nop, add, halt → instr_count=3, frozen in HALT_ST.
